// File: rtl/ring_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ring_pkg
// Description : Shared types and defaults for the one-hot ring monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package ring_pkg;

    // Lock-tracking state encoding
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } ring_state_t;

    localparam int c_N_DEFAULT        = 4;
    localparam int c_LOCK_CNT_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/onehot_encoder.sv
`default_nettype none
// ============================================================================
// Module      : onehot_encoder
// Description : Combinational one-hot to binary encoder with a flag that is
//               high only when exactly one input bit is set.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_encoder
    import ring_pkg::*;
#(
    parameter int N = c_N_DEFAULT
) (
    input  logic [N-1:0]         y,
    output logic [$clog2(N)-1:0] idx,
    output logic                 onehot
);

    localparam int c_IDX_W = $clog2(N);

    // Non-zero with no second bit set means exactly one bit; idx is only
    // meaningful when onehot is high.
    always_comb begin
        idx    = '0;
        onehot = (y != '0) && ((y & (y - 1'b1)) == '0);
        for (int i = 0; i < N; i++) begin
            if (y[i]) begin
                idx = c_IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/onehot_ring_monitor.sv
`default_nettype none
// ============================================================================
// Module      : onehot_ring_monitor
// Description : Watches a one-hot ring counter phase, tracks sequential
//               stepping, declares lock after LOCK_CNT correct steps and
//               counts (saturating) every loss of lock.
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_ring_monitor
    import ring_pkg::*;
#(
    parameter int N        = c_N_DEFAULT,
    parameter int LOCK_CNT = c_LOCK_CNT_DEFAULT,
    parameter int ERR_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N-1:0]         y_in,
    input  logic                 err_clr,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_W-1:0]     err_count
);

    localparam int             c_IDX_W   = $clog2(N);
    localparam logic [3:0]     c_LOCK    = 4'(LOCK_CNT);
    localparam logic [ERR_W-1:0] c_ERR_MAX = {ERR_W{1'b1}};

    ring_state_t        r_state;
    ring_state_t        w_state_nxt;
    logic [3:0]         r_match_cnt;
    logic [3:0]         w_match_cnt_nxt;
    logic [3:0]         w_cnt_inc;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_valid;
    logic               r_err;
    logic               w_err_nxt;
    logic [ERR_W-1:0]   r_err_count;

    logic [c_IDX_W-1:0] w_enc_idx;
    logic               w_onehot;
    logic [c_IDX_W-1:0] w_idx_inc;
    logic               w_seq;

    onehot_encoder #(
        .N      (N)
    ) u_enc (
        .y      (y_in),
        .idx    (w_enc_idx),
        .onehot (w_onehot)
    );

    // Expected next phase of the ring; wraps N-1 back to 0 for any N
    assign w_idx_inc = (r_idx == c_IDX_W'(N - 1)) ? '0 : r_idx + 1'b1;
    assign w_seq     = w_onehot && (w_enc_idx == w_idx_inc);
    assign w_cnt_inc = r_match_cnt + 4'd1;

    // Next-state / step-count / loss-of-lock decision
    always_comb begin
        w_state_nxt     = r_state;
        w_match_cnt_nxt = r_match_cnt;
        w_err_nxt       = 1'b0;
        if (en) begin
            case (r_state)
                SEARCH: begin
                    if (w_onehot) begin
                        w_state_nxt     = TRACK;
                        w_match_cnt_nxt = 4'd1;
                    end
                end
                TRACK: begin
                    if (w_seq) begin
                        w_match_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc >= c_LOCK) begin
                            w_state_nxt = LOCKED;
                        end
                    end else if (w_onehot) begin
                        w_match_cnt_nxt = 4'd1;
                    end else begin
                        w_state_nxt     = SEARCH;
                        w_match_cnt_nxt = 4'd0;
                    end
                end
                LOCKED: begin
                    if (!w_seq) begin
                        w_err_nxt = 1'b1;
                        if (w_onehot) begin
                            w_state_nxt     = TRACK;
                            w_match_cnt_nxt = 4'd1;
                        end else begin
                            w_state_nxt     = SEARCH;
                            w_match_cnt_nxt = 4'd0;
                        end
                    end
                end
                default: begin
                    w_state_nxt     = SEARCH;
                    w_match_cnt_nxt = 4'd0;
                end
            endcase
        end
    end

    // State, sample registers, error pulse and saturating error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SEARCH;
            r_match_cnt <= 4'd0;
            r_idx       <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (en) begin
                r_state     <= w_state_nxt;
                r_match_cnt <= w_match_cnt_nxt;
                r_valid     <= w_onehot;
                if (w_onehot) begin
                    r_idx <= w_enc_idx;
                end
            end
            r_err <= w_err_nxt;
            // A clear coinciding with a loss still records that loss
            if (err_clr) begin
                r_err_count <= w_err_nxt ? ERR_W'(1) : '0;
            end else if (w_err_nxt && (r_err_count != c_ERR_MAX)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign idx       = r_idx;
    assign valid     = r_valid;
    assign locked    = (r_state == LOCKED);
    assign err       = r_err;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_onehot_ring_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_onehot_ring_monitor
// Description : Scoreboard bench for onehot_ring_monitor. A run-length
//               reference model predicts each cycle's outputs; a monitor
//               process compares them one cycle after the sampling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_ring_monitor;

    localparam int c_N        = 4;
    localparam int c_LOCK_CNT = 4;
    localparam int c_ERR_W    = 8;
    localparam int c_ERR_MAX  = (1 << c_ERR_W) - 1;

    typedef struct {
        int idx;
        int valid;
        int locked;
        int err;
        int cnt;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   en = 1'b0;
    logic [c_N-1:0]         y_in = '0;
    logic                   err_clr = 1'b0;
    logic [$clog2(c_N)-1:0] idx;
    logic                   valid;
    logic                   locked;
    logic                   err;
    logic [c_ERR_W-1:0]     err_count;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int m_idx = 0, m_valid = 0, m_run = 0, m_locked = 0, m_err = 0, m_cnt = 0;
    int phase = 0;

    onehot_ring_monitor #(
        .N         (c_N),
        .LOCK_CNT  (c_LOCK_CNT),
        .ERR_W     (c_ERR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .y_in      (y_in),
        .err_clr   (err_clr),
        .idx       (idx),
        .valid     (valid),
        .locked    (locked),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Lock is simply "the last LOCK_CNT valid samples formed an unbroken
    // ascending ring walk"; losing that condition is one error event.
    task automatic model(input bit r, input bit e, input logic [c_N-1:0] y, input bit c);
        int p;
        int nl;
        int ev;
        if (r) begin
            m_idx = 0; m_valid = 0; m_run = 0; m_locked = 0; m_err = 0; m_cnt = 0;
            return;
        end
        ev = 0;
        if (e) begin
            m_valid = ($countones(y) == 1) ? 1 : 0;
            if (m_valid != 0) begin
                p = $clog2(int'(y));
                if (m_run > 0 && p == (m_idx + 1) % c_N)
                    m_run = (m_run + 1 > c_LOCK_CNT) ? c_LOCK_CNT : m_run + 1;
                else
                    m_run = 1;
                m_idx = p;
            end else begin
                m_run = 0;
            end
            nl = (m_run >= c_LOCK_CNT) ? 1 : 0;
            ev = (m_locked != 0 && nl == 0) ? 1 : 0;
            m_locked = nl;
        end
        m_err = ev;
        if (c) m_cnt = ev;
        else if (ev != 0 && m_cnt < c_ERR_MAX) m_cnt = m_cnt + 1;
    endtask

    task automatic step(input bit r, input bit e, input logic [c_N-1:0] y, input bit c);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; y_in = y; err_clr = c;
        model(r, e, y, c);
        x.idx = m_idx; x.valid = m_valid; x.locked = m_locked;
        x.err = m_err; x.cnt = m_cnt;
        q.push_back(x);
    endtask

    function automatic logic [c_N-1:0] oh(input int p);
        return c_N'(1 << p);
    endfunction

    // Lock from SEARCH: phases 0..LOCK_CNT-1
    task automatic lock_up();
        for (int i = 0; i < c_LOCK_CNT; i++) step(0, 1, oh(i % c_N), 0);
        phase = (c_LOCK_CNT - 1) % c_N;
    endtask

    // Monitor: the DUT presents a fresh result every cycle after the edge
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("idx",       int'(idx),       x.idx);
                chk("valid",     int'(valid),     x.valid);
                chk("locked",    int'(locked),    x.locked);
                chk("err",       int'(err),       x.err);
                chk("err_count", int'(err_count), x.cnt);
            end
        end
    end

    initial begin
        int sel;
        logic [c_N-1:0] y;
        // Reset
        step(1, 0, '0, 0);
        step(1, 1, 4'b0001, 1);
        // Basic lock: 0001,0010,0100,1000
        lock_up();
        step(0, 1, oh(0), 0);
        // Non-sequential valid sample while locked
        step(0, 1, oh(2), 0);
        // Recover and lock, then zero and multi-bit samples
        step(0, 1, oh(3), 0);
        step(0, 1, oh(0), 0);
        step(0, 1, oh(1), 0);
        step(0, 1, 4'b0000, 0);
        step(0, 1, 4'b0110, 0);
        // Repeated index breaks lock
        lock_up();
        step(0, 1, oh(3), 0);
        // en low holds everything while locked
        step(0, 1, 4'b0000, 0);
        lock_up();
        for (int i = 0; i < 5; i++) step(0, 0, c_N'($urandom), 0);
        step(0, 1, oh(0), 0);
        step(0, 1, oh(1), 0);
        // Saturate the error counter
        step(0, 1, 4'b0000, 0);
        for (int k = 0; k < c_ERR_MAX + 4; k++) begin
            lock_up();
            step(0, 1, 4'b0000, 0);
        end
        // Clear with simultaneous loss, then clear alone
        lock_up();
        step(0, 1, 4'b1100, 1);
        step(0, 1, oh(0), 1);
        // Reset while locked
        lock_up();
        step(1, 1, oh(0), 0);
        step(0, 0, '0, 0);
        // Randomized traffic
        phase = 0;
        for (int k = 0; k < 3000; k++) begin
            sel = $urandom_range(0, 99);
            if (sel < 70) begin
                phase = (phase + 1) % c_N;
                y = oh(phase);
            end else if (sel < 80) begin
                y = oh(phase);
            end else if (sel < 88) begin
                phase = $urandom_range(0, c_N - 1);
                y = oh(phase);
            end else if (sel < 94) begin
                y = '0;
            end else begin
                y = c_N'($urandom);
            end
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                 y, ($urandom_range(0, 49) == 0));
        end
        step(0, 0, '0, 0);
        // Drain the scoreboard within a bounded number of cycles
        for (int w = 0; w < 20 && q.size() > 0; w++) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/onehot_ring_monitor.md
ONEHOT_RING_MONITOR -- requirements
Module: onehot_ring_monitor

Interface
REQ-001 Parameter N, 4: ring width, i.e. one-hot phase vector width.
REQ-002 Parameter LOCK_CNT, 4: consecutive correct steps required to declare lock; legal range 2..15.
REQ-003 Parameter ERR_W, 8: width of error counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 en  in  1  sample enable; when low, y_in is ignored and all state holds.
REQ-007 y_in  in  N  one-hot ring phase from a ring counter; bit 0 is phase 0, rotating upward.
REQ-008 err_clr  in  1  synchronous clear of err_count.
REQ-009 idx  out  log2(N)  binary index of last valid one-hot sample, registered.
REQ-010 valid  out  1  registered; high when the last enabled sample had exactly one bit set.
REQ-011 locked  out  1  high while state is LOCKED.
REQ-012 err  out  1  one-cycle pulse on loss of lock.
REQ-013 err_count  out  ERR_W  saturating count of lock losses.

Function
REQ-014 Latency: a sample taken at edge k with en=1 appears on idx/valid/locked/err after edge k (1 cycle).
REQ-015 Encoding: exactly one bit set -> valid=1, idx=bit position; zero or multiple bits set -> valid=0, idx holds previous value.
REQ-016 Step rule: a sample is "sequential" when valid and idx_new == (idx_prev + 1) mod N, idx_prev being the last valid index.
REQ-017 FSM states: SEARCH, TRACK, LOCKED; internal step counter match_cnt (4 bits).
REQ-018 SEARCH: valid sample -> TRACK, match_cnt=1; invalid sample -> stay SEARCH.
REQ-019 TRACK: sequential sample -> match_cnt+1; when match_cnt reaches LOCK_CNT -> LOCKED.
REQ-020 TRACK: valid non-sequential sample -> stay TRACK, match_cnt=1 (restart from that sample); invalid sample -> SEARCH, match_cnt=0.
REQ-021 LOCKED: sequential sample -> stay LOCKED.
REQ-022 LOCKED: valid non-sequential sample -> err pulse, TRACK with match_cnt=1; invalid sample -> err pulse, SEARCH.
REQ-023 Repeated index (idx_new == idx_prev) counts as non-sequential.
REQ-024 en=0: state, match_cnt, idx, valid, locked unchanged; err forced 0.
REQ-025 err_count increments by 1 on each err pulse; saturates at 2^ERR_W-1, no wrap.
REQ-026 err_clr and err pulse in the same cycle -> err_count=1; err_clr alone -> err_count=0.
REQ-027 Wrap-around: idx N-1 followed by idx 0 is sequential.

Reset
REQ-028 rst=1 at an edge: state=SEARCH, match_cnt=0, idx=0, valid=0, locked=0, err=0, err_count=0.
REQ-029 rst has priority over en, err_clr and any in-progress lock; no err pulse is generated by reset.
REQ-030 First sample after reset release is treated as in SEARCH, with no idx_prev comparison.

Structure
REQ-031 Shared package ring_pkg holds the state encoding (SEARCH=0, TRACK=1, LOCKED=2) and the defaults for N and LOCK_CNT.
REQ-032 Combinational sub-module onehot_encoder (y_in -> idx, onehot flag) is instantiated once; FSM and counters live in the top.

Verification
REQ-033 rst, then y_in 0001,0010,0100,1000 with en=1 -> locked rises after the 4th sample; idx 0,1,2,3; err=0.
REQ-034 Locked, then inject 0100 after 0001 -> err pulses once, locked=0, err_count=1, state TRACK, idx=2.
REQ-035 Locked, then y_in=0000 and then 0110 -> valid=0 on both, idx holds, one err pulse, state SEARCH, err_count increments by exactly 1.
REQ-036 Locked, en=0 for 5 cycles with random y_in, then the sequential sample -> locked stays 1 throughout, no err.
REQ-037 Force 2^ERR_W+3 lock losses -> err_count stays 255; err_clr together with an err pulse -> err_count=1.
REQ-038 Assert rst while LOCKED -> next cycle all outputs 0, state SEARCH, err=0.
